// File: rtl/pencoder_seq.sv
// -----------------------------------------------------------------------------
// pencoder_seq
//
// Sequential priority encoder. A request vector is accepted over a valid/ready
// handshake. The block then emits the index of every set bit, one per output
// beat, lowest index first (MSB_FIRST=0) or highest index first (MSB_FIRST=1).
// Each beat also carries a last-beat flag and its ordinal within the vector.
// An all-zero vector produces a single "empty" beat.
//
// Parameters:
//   WIDTH     - request vector width (2..1024)
//   MSB_FIRST - 0: lowest set index first, 1: highest set index first
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   flush     - synchronous abort of the vector in flight (beats both handshakes)
//   in_valid  - in_vec is valid
//   in_ready  - block can accept a vector (high in IDLE)
//   in_vec    - request bits, sampled only at the capture edge
//   out_valid - a beat is presented (high in BUSY)
//   out_ready - consumer accepts the beat
//   out_idx   - index of the highest-priority pending bit
//   out_last  - this beat is the final one for the vector
//   out_empty - the captured vector was all-zero; out_idx carries no index
//   out_seq   - ordinal of this beat within its vector, from 0
// -----------------------------------------------------------------------------
module pencoder_seq #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_vec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] out_idx,
    output logic                     out_last,
    output logic                     out_empty,
    output logic [$clog2(WIDTH)-1:0] out_seq
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q,  pend_d;
    logic             zflag_q, zflag_d;
    logic [IW-1:0]    seq_q,   seq_d;

    logic [IW-1:0]    enc_idx;
    logic             enc_found;
    logic             pend_single;
    logic             busy;
    logic             beat_last;

    // -------------------------------------------------------------------------
    // Priority encoder over the pending bits. The first set bit met in scan
    // order wins, so the scan direction alone selects the priority order.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first; a path that leaves one unassigned would infer a latch.
        enc_idx   = '0;
        enc_found = 1'b0;
        if (MSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (!enc_found && pend_q[i]) begin
                    enc_idx   = IW'(i);
                    enc_found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!enc_found && pend_q[i]) begin
                    enc_idx   = IW'(i);
                    enc_found = 1'b1;
                end
            end
        end
    end

    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    assign pend_single = (pend_q != '0) &&
                         ((pend_q & (pend_q - WIDTH'(1))) == '0);

    assign busy      = (state_q == BUSY);
    assign beat_last = zflag_q | pend_single;

    // -------------------------------------------------------------------------
    // Next-state logic. flush is checked first so it overrides both handshakes.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        zflag_d = zflag_q;
        seq_d   = seq_q;

        if (flush) begin
            state_d = IDLE;
            pend_d  = '0;
            zflag_d = 1'b0;
            seq_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        pend_d  = in_vec;
                        zflag_d = (in_vec == '0);
                        seq_d   = '0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (out_ready) begin
                        // For an empty beat pend is already zero, so clearing
                        // bit 0 is harmless.
                        pend_d[enc_idx] = 1'b0;
                        if (beat_last) begin
                            // Restart the ordinal here rather than incrementing:
                            // a full vector would otherwise carry seq to WIDTH.
                            state_d = IDLE;
                            zflag_d = 1'b0;
                            seq_d   = '0;
                        end else begin
                            seq_d = seq_q + IW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            zflag_q <= 1'b0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            zflag_q <= zflag_d;
            seq_q   <= seq_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs depend on registered state only. Beat fields are gated with BUSY
    // so the block shows all-zero beat fields whenever it is idle.
    // -------------------------------------------------------------------------
    assign in_ready  = !busy;
    assign out_valid = busy;
    assign out_idx   = busy ? enc_idx : '0;
    assign out_last  = busy & beat_last;
    assign out_empty = busy & zflag_q;
    assign out_seq   = seq_q;

endmodule

// File: tb/tb_pencoder_seq.sv
// -----------------------------------------------------------------------------
// tb_pencoder_seq
//
// Bench for pencoder_seq. Two WIDTH=8 instances (LSB-first and MSB-first) share
// one set of inputs and run in lockstep; a WIDTH=31 LSB-first instance is used
// for a randomized sweep. Expected beats come from a reference model that just
// lists the set bit positions of the captured vector in priority order.
// -----------------------------------------------------------------------------
module tb_pencoder_seq;

    typedef int iq_t[$];

    logic clk = 1'b0;
    logic rst_n;

    // Shared stimulus for the two WIDTH=8 instances.
    logic       flush;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       l_in_ready, l_out_valid, l_out_last, l_out_empty;
    logic [2:0] l_out_idx, l_out_seq;
    logic       m_in_ready, m_out_valid, m_out_last, m_out_empty;
    logic [2:0] m_out_idx, m_out_seq;

    // WIDTH=31 instance.
    logic        w_flush;
    logic        w_in_valid;
    logic [30:0] w_in_vec;
    logic        w_out_ready;
    logic        w_in_ready, w_out_valid, w_out_last, w_out_empty;
    logic [4:0]  w_out_idx, w_out_seq;

    int n_pass  = 0;
    int n_total = 0;

    pencoder_seq #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(l_in_ready), .in_vec(in_vec),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_idx(l_out_idx),
        .out_last(l_out_last), .out_empty(l_out_empty), .out_seq(l_out_seq)
    );

    pencoder_seq #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_vec(in_vec),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_idx(m_out_idx),
        .out_last(m_out_last), .out_empty(m_out_empty), .out_seq(m_out_seq)
    );

    pencoder_seq #(.WIDTH(31), .MSB_FIRST(1'b0)) u_w31 (
        .clk(clk), .rst_n(rst_n), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_vec(w_in_vec),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_idx(w_out_idx),
        .out_last(w_out_last), .out_empty(w_out_empty), .out_seq(w_out_seq)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Beat fields packed as {valid, last, empty, idx[9:0], seq[9:0]}.
    function automatic logic [31:0] pack(logic v, logic l, logic e,
                                         logic [9:0] idx, logic [9:0] seq);
        return {9'b0, v, l, e, idx, seq};
    endfunction

    function automatic logic [31:0] beat_lsb();
        return pack(l_out_valid, l_out_last, l_out_empty, 10'(l_out_idx), 10'(l_out_seq));
    endfunction

    function automatic logic [31:0] beat_msb();
        return pack(m_out_valid, m_out_last, m_out_empty, 10'(m_out_idx), 10'(m_out_seq));
    endfunction

    function automatic logic [31:0] beat_w31();
        return pack(w_out_valid, w_out_last, w_out_empty, 10'(w_out_idx), 10'(w_out_seq));
    endfunction

    // Reference model: set bit positions of v in the order they must leave.
    function automatic iq_t order(logic [31:0] v, int w, bit msb);
        iq_t q;
        for (int k = 0; k < w; k++) begin
            if (v[k]) begin
                if (msb) q.push_front(k);
                else     q.push_back(k);
            end
        end
        return q;
    endfunction

    // Expected beat j of a vector whose ordered index list is q.
    function automatic logic [31:0] exp_beat(iq_t q, int j);
        if (q.size() == 0) return pack(1'b1, 1'b1, 1'b1, 10'd0, 10'd0);
        return pack(1'b1, (j == q.size() - 1), 1'b0, 10'(q[j]), 10'(j));
    endfunction

    // Offer one vector to both WIDTH=8 instances and walk all its beats.
    // out_ready is held low for the first stall_first beat cycles, then is
    // either always high or random. cycles returns the number of BUSY cycles.
    task automatic run_vec8(input logic [7:0] v, input int stall_first,
                            input bit rand_bp, output int cycles);
        iq_t ql, qm;
        int  n, j;
        ql = order({24'b0, v}, 8, 1'b0);
        qm = order({24'b0, v}, 8, 1'b1);
        n  = (ql.size() == 0) ? 1 : ql.size();
        check("ready_before_capture", {30'b0, l_in_ready, m_in_ready}, 32'd3);
        in_valid  = 1'b1;
        in_vec    = v;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_vec   = 8'($urandom);
        j = 0;
        cycles = 0;
        while (j < n && cycles < 200) begin
            check($sformatf("lsb_beat v=%02h j=%0d", v, j), beat_lsb(), exp_beat(ql, j));
            check($sformatf("msb_beat v=%02h j=%0d", v, j), beat_msb(), exp_beat(qm, j));
            if (cycles < stall_first) out_ready = 1'b0;
            else if (rand_bp)         out_ready = ($urandom_range(0, 2) != 0);
            else                      out_ready = 1'b1;
            tick();
            if (out_ready) j++;
            cycles++;
        end
        out_ready = 1'b0;
        check($sformatf("idle_after v=%02h", v),
              {28'b0, l_in_ready, l_out_valid, m_in_ready, m_out_valid}, 32'b1010);
    endtask

    // Same walk for the WIDTH=31 instance.
    task automatic run_vec31(input logic [30:0] v, input bit rand_bp);
        iq_t q;
        int  n, j, cyc;
        q = order({1'b0, v}, 31, 1'b0);
        n = (q.size() == 0) ? 1 : q.size();
        check("w31_ready", {31'b0, w_in_ready}, 32'd1);
        w_in_valid  = 1'b1;
        w_in_vec    = v;
        w_out_ready = 1'b0;
        tick();
        w_in_valid = 1'b0;
        w_in_vec   = 31'($urandom);
        j = 0;
        cyc = 0;
        while (j < n && cyc < 400) begin
            check($sformatf("w31_beat v=%08h j=%0d", v, j), beat_w31(), exp_beat(q, j));
            w_out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            tick();
            if (w_out_ready) j++;
            cyc++;
        end
        w_out_ready = 1'b0;
        check($sformatf("w31_idle_after v=%08h", v), {30'b0, w_in_ready, w_out_valid}, 32'b10);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        int cyc;
        logic [31:0] idle_beat;
        idle_beat = pack(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);

        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        w_flush = 1'b0; w_in_valid = 1'b0; w_in_vec = '0; w_out_ready = 1'b0;
        tick();
        tick();
        check("reset_lsb_beat", beat_lsb(), idle_beat);
        check("reset_ready", {29'b0, l_in_ready, m_in_ready, w_in_ready}, 32'd7);
        rst_n = 1'b1;
        tick();

        // LSB/MSB walk of 0x96: 4 BUSY cycles, then IDLE.
        run_vec8(8'h96, 0, 1'b0, cyc);
        check("walk_0x96_cycles", 32'(cyc), 32'd4);

        // Backpressure: first beat held for 3 cycles.
        run_vec8(8'h21, 3, 1'b0, cyc);
        check("bp_0x21_cycles", 32'(cyc), 32'd5);

        // Zero and all-ones vectors.
        run_vec8(8'h00, 0, 1'b0, cyc);
        check("zero_cycles", 32'(cyc), 32'd1);
        run_vec8(8'hFF, 0, 1'b0, cyc);
        check("ones_cycles", 32'(cyc), 32'd8);

        // Flush after the 2nd beat of 0xFF.
        in_valid = 1'b1; in_vec = 8'hFF;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        check("pre_flush_lsb", beat_lsb(), pack(1'b1, 1'b0, 1'b0, 10'd2, 10'd2));
        check("pre_flush_msb", beat_msb(), pack(1'b1, 1'b0, 1'b0, 10'd5, 10'd2));
        flush = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        check("post_flush_lsb", beat_lsb(), idle_beat);
        check("post_flush_ready", {30'b0, l_in_ready, m_in_ready}, 32'd3);
        tick();
        check("post_flush_stale", {30'b0, l_out_valid, m_out_valid}, 32'd0);

        // Flush together with in_valid in IDLE: nothing captured.
        flush = 1'b1; in_valid = 1'b1; in_vec = 8'h55;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_cap_lsb", beat_lsb(), idle_beat);
        check("flush_cap_ready", {30'b0, l_in_ready, m_in_ready}, 32'd3);

        // Reset asserted mid-vector.
        in_valid = 1'b1; in_vec = 8'h96;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        check("rst_mid_beat0", beat_lsb(), pack(1'b1, 1'b0, 1'b0, 10'd1, 10'd0));
        tick();
        check("rst_mid_beat1", beat_lsb(), pack(1'b1, 1'b0, 1'b0, 10'd2, 10'd1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_lsb", beat_lsb(), idle_beat);
        check("rst_async_msb", beat_msb(), idle_beat);
        check("rst_async_ready", {30'b0, l_in_ready, m_in_ready}, 32'd3);
        out_ready = 1'b0; in_valid = 1'b1; in_vec = 8'h96;
        tick();
        check("rst_no_capture", beat_lsb(), idle_beat);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        check("rst_release_idle", beat_lsb(), idle_beat);
        run_vec8(8'h01, 0, 1'b0, cyc);
        check("after_rst_cycles", 32'(cyc), 32'd1);

        // Random vectors with random backpressure on the WIDTH=8 pair.
        for (int r = 0; r < 20; r++) begin
            run_vec8(8'($urandom), 0, 1'b1, cyc);
        end

        // WIDTH=31 sweep.
        run_vec31(31'h0, 1'b0);
        run_vec31(31'h7FFF_FFFF, 1'b0);
        run_vec31(31'h4000_0001, 1'b1);
        for (int r = 0; r < 25; r++) begin
            run_vec31(31'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pencoder_seq.md
# pencoder_seq

Sequential, parametrised successor to the combinational priority encoder. It accepts a request bit-vector over a valid/ready handshake and emits the index of every set bit, one per output beat, in a configurable priority order. It also flags the last beat and reports a beat ordinal. It sits between request-collection logic (wakeup/ready vectors, pending-miss masks) and consumers that service one entry per cycle.

## Interface
- WIDTH, 32, request vector width; legal range 2..1024.
- MSB_FIRST, 0, 0: lowest set index is emitted first; 1: highest set index first.
- IW (localparam), $clog2(WIDTH), index width.
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the vector in flight.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block can accept a vector.
- in_vec  in  WIDTH  request bits.
- out_valid  out  1  out_idx is valid.
- out_ready  in  1  consumer accepts the beat.
- out_idx  out  IW  index of the current highest-priority pending bit.
- out_last  out  1  current beat is the final beat for this vector.
- out_empty  out  1  accepted vector was all-zero; beat carries no index.
- out_seq  out  IW  ordinal of the beat within its vector, starting at 0.

## Operation
- Two states, IDLE and BUSY. Registers: state, pend[WIDTH], zflag, seq[IW].
- **IDLE**
  - in_ready=1 and out_valid=0.
  - When in_valid & in_ready: pend<=in_vec, zflag<=(in_vec==0), seq<=0, state<=BUSY.
- **BUSY**
  - in_ready=0 and out_valid=1.
  - out_idx = priority encode of pend: lowest set bit if MSB_FIRST=0, highest if 1.
  - out_last = zflag | (pend has exactly one bit set).
  - out_empty = zflag. When zflag=1, out_idx=0.
  - out_seq = seq.
- **Beat handshake** (out_valid & out_ready)
  - Clear pend[out_idx] and increment seq.
  - If out_last, go to IDLE.
- **Output stability**: out_idx, out_last, out_empty and out_seq are driven from registers only, with no combinational path from any input. They hold stable while out_valid & !out_ready.
- **flush=1** (any state): state<=IDLE, pend<=0, zflag<=0, seq<=0.
  - flush takes priority over both handshakes in the same cycle.
  - A vector offered in a flush cycle is not captured.
- **Zero vector**: produces exactly one beat (out_empty=1, out_last=1, out_seq=0).
- **Ordering**: beats leave in strict priority order. Input bits are sampled only at the capture edge; later in_vec changes have no effect on the vector in flight.
- **seq range**: seq never exceeds WIDTH-1, so it cannot wrap.

## Timing
- **Reset** (rst_n low, asynchronous):
  - state=IDLE, pend=0, zflag=0, seq=0.
  - Outputs: in_ready=1, out_valid=0, out_idx=0, out_last=0, out_empty=0, out_seq=0.
  - No capture occurs while rst_n is low.
  - Reset asserted mid-vector discards the vector; no further beats are emitted.
- **Latency**: a vector captured at edge N gives out_valid=1 from edge N (visible in cycle N+1).
- **Throughput**: with out_ready held high, a vector with k set bits (k≥1) occupies k BUSY cycles plus one IDLE cycle. An all-zero vector takes 1+1 cycles.
- **Back-to-back vectors**: in_ready rises in the cycle after the last-beat handshake.
- **Encoder path**: a single WIDTH-bit priority encode from pend to out_idx. If timing requires, it is built as a log-depth tree.

## Test plan
- **Reset mid-stream**: reset asserted in BUSY with pend=0x96 -> all outputs at their reset values, with in_ready=1 immediately. Release, then present 0x01 -> one beat idx=0, last=1.
- **LSB-first walk**: WIDTH=8, MSB_FIRST=0, in_vec=0x96, out_ready=1 -> beats idx 1,2,4,7 with seq 0,1,2,3. out_last=1 only on idx 7. in_ready=1 in the following cycle. Total 5 cycles.
- **MSB-first walk**: MSB_FIRST=1, in_vec=0x96 -> idx 7,4,2,1, last on idx 1.
- **Backpressure**: in_vec=0x21, out_ready low for 3 cycles -> idx=0, seq=0 held stable for 3 cycles. Then out_ready=1 -> idx 0, then idx 5 with last=1.
- **Zero vector and all-ones vector**:
  - in_vec=0x00 -> a single beat with out_empty=1, out_last=1, idx=0, seq=0.
  - in_vec=0xFF -> 8 beats idx 0..7, seq 0..7.
  - WIDTH=31 sweep with an LSB-first model: every beat matches, popcount beats per vector.
- **Flush**:
  - flush after the 2nd beat of 0xFF -> next cycle out_valid=0 and in_ready=1, no stale beats.
  - flush together with in_valid in IDLE -> vector not captured.
